fifo_fwft: RTL
==============

// Module: fifo_fwft
// PURPOSE
//  Synchronous single-clock FIFO with first-word-fall-through (FWFT) read.
//  Generalised successor of the basic queue: any depth >= 2 (power of two not required),
//  programmable almost-full/almost-empty flags, occupancy/free counts and synchronous flush.
//  Buffers streams between pipeline stages, e.g. fetch->decode and bus response paths.
// PARAMETERS
//  DATA_WIDTH  32  word width in bits
//  FIFO_DEPTH  16  number of entries, >= 2, any integer
//  AF_MARGIN   2   almost_full_out asserts when free_out <= AF_MARGIN (0 <= AF_MARGIN < FIFO_DEPTH)
//  AE_MARGIN   2   almost_empty_out asserts when count_out <= AE_MARGIN (0 <= AE_MARGIN < FIFO_DEPTH)
//  (localparams ADDR_W = $clog2(FIFO_DEPTH), CNT_W = $clog2(FIFO_DEPTH+1))
// PORTS
//  clk               in   1           clock, all state on rising edge
//  rst               in   1           asynchronous active-high reset
//  data_in           in   DATA_WIDTH  write data
//  write_en_in       in   1           write request
//  full_out          out  1           no free entry
//  almost_full_out   out  1           free_out <= AF_MARGIN
//  data_out          out  DATA_WIDTH  head-of-queue word, valid while empty_out==0
//  read_en_in        in   1           pop head (acknowledge data_out)
//  empty_out         out  1           no stored entry
//  almost_empty_out  out  1           count_out <= AE_MARGIN
//  flush_in          in   1           synchronous clear of all contents
//  count_out         out  CNT_W       stored entries
//  free_out          out  CNT_W       FIFO_DEPTH - count_out
// BEHAVIOUR
//  - Reset (async assert, sync release): rd/wr pointers 0, count 0 -> empty_out=1, full_out=0,
//    almost_empty_out=1, almost_full_out=0, free_out=FIFO_DEPTH, data_out=0. Memory not reset.
//  - write_req = write_en_in & (~full_out | read_req); read_req = read_en_in & ~empty_out.
//  - Write at edge N: memory[wr_ptr] <= data_in; word visible on data_out at N+1 if queue was empty.
//  - FWFT: data_out = memory[rd_ptr] combinationally while !empty_out; forced to 0 while empty.
//    Read at edge N pops head; next word (or 0) appears after edge N.
//  - Count: +1 on write only, -1 on read only, unchanged on both or neither.
//  - All flags/counts decode combinationally from the count register; they change only after an edge.
//  - Full + read_en + write_en: both accepted, count stays FIFO_DEPTH (pass-through slot reuse).
//  - Empty + read_en + write_en: read ignored, write accepted, count -> 1. No same-cycle bypass.
//  - Write while full (no read) / read while empty: silently dropped, no state change.
//  - Pointers wrap from FIFO_DEPTH-1 to 0 (explicit compare, not power-of-two rollover).
//  - flush_in has priority: at the edge, pointers/count -> 0, data_out -> 0; same-cycle
//    read and write are dropped. flush while empty is a no-op.
//  - rst mid-operation: contents lost, outputs return to reset values immediately.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined: adds ports overflow_out (out 1), underflow_out (out 1), err_clr_in (in 1).
//    overflow_out sets sticky on a write dropped because full; underflow_out on read_en_in while empty.
//    Cleared by rst or err_clr_in (clear wins over same-cycle set); flush_in does not clear.
//  Not defined: ports absent, dropped requests leave no trace.
// STRUCTURE
//  fifo_pkg: fifo_err_t struct {overflow, underflow}; clog2-based width helper functions.
//  Sub-module fifo_ptr #(DEPTH): ADDR_W pointer, inc_in, clr_in, async rst, wraps at DEPTH-1;
//    instanced twice (read, write). Storage is a plain reg array in fifo_fwft.
// TESTING
//  1 Reset, DEPTH=16 -> empty=1, full=0, ae=1, af=0, count=0, free=16, data_out=0.
//  2 DEPTH=5: write 0xA0..0xA4 -> full=1 after 5th; 6th write dropped (overflow_out=1 if EN);
//    drain 5 -> exact order A0..A4, empty=1.
//  3 Write 0x11 to empty -> next cycle empty=0, data_out=0x11; read+write same cycle keeps count.
//  4 DEPTH=5 full, read_en=write_en=1 for 12 cycles -> full stays 1, output order preserved across wraps.
//  5 AF/AE_MARGIN=2, DEPTH=16: count 2 -> ae=1; 3 -> ae=0; 14 -> af=1; 13 -> af=0.
//  6 count=7, flush with read+write same cycle -> count=0, empty=1, data_out=0; rst mid-burst same.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and width helpers for the FWFT FIFO.
package fifo_pkg;
   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;
   function automatic int addr_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fifo_fwft_if.sv
// fifo_fwft_if: write/read/flush/status bundle of the FWFT FIFO.
// FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags and their clear.
interface fifo_fwft_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 5
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  write_en_in;
   logic                  full_out;
   logic                  almost_full_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  read_en_in;
   logic                  empty_out;
   logic                  almost_empty_out;
   logic                  flush_in;
   logic [CNT_W-1:0]      count_out;
   logic [CNT_W-1:0]      free_out;
`ifdef FIFO_ERR_FLAGS_EN
   logic                  overflow_out;
   logic                  underflow_out;
   logic                  err_clr_in;
   modport slave (
      input  data_in, write_en_in, read_en_in, flush_in, err_clr_in,
      output full_out, almost_full_out, data_out, empty_out, almost_empty_out,
             count_out, free_out, overflow_out, underflow_out
   );
   modport master (
      output data_in, write_en_in, read_en_in, flush_in, err_clr_in,
      input  full_out, almost_full_out, data_out, empty_out, almost_empty_out,
             count_out, free_out, overflow_out, underflow_out
   );
`else
   modport slave (
      input  data_in, write_en_in, read_en_in, flush_in,
      output full_out, almost_full_out, data_out, empty_out, almost_empty_out,
             count_out, free_out
   );
   modport master (
      output data_in, write_en_in, read_en_in, flush_in,
      input  full_out, almost_full_out, data_out, empty_out, almost_empty_out,
             count_out, free_out
   );
`endif
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping address pointer for any depth (explicit compare, not pow2 rollover).
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_in,
   input  logic              clr_in,
   output logic [ADDR_W-1:0] ptr_out
);
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   always_comb
      ptr_d = clr_in ? '0 :
              !inc_in ? ptr_q :
              (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   assign ptr_out = ptr_q;
endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: single-clock first-word-fall-through FIFO, any depth >= 2, with flush and status.
// FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags cleared by err_clr_in.
module fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_MARGIN  = 2,
   parameter int AE_MARGIN  = 2
) (
   input logic       clk,
   input logic       rst,
   fifo_fwft_if.slave q
);
   localparam int ADDR_W = addr_w(FIFO_DEPTH);
   localparam int CNT_W  = cnt_w(FIFO_DEPTH);
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count_q, count_d, free;
   logic                  empty, full, rd_req, wr_req;
   assign empty  = count_q == '0;
   assign full   = count_q == CNT_W'(FIFO_DEPTH);
   assign free   = CNT_W'(FIFO_DEPTH) - count_q;
   assign rd_req = q.read_en_in & ~empty;
   // a full queue still accepts a write when the head is popped in the same cycle
   assign wr_req = q.write_en_in & (~full | rd_req);
   fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
      .clk, .rst, .inc_in(rd_req & ~q.flush_in), .clr_in(q.flush_in), .ptr_out(rd_ptr)
   );
   fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
      .clk, .rst, .inc_in(wr_req & ~q.flush_in), .clr_in(q.flush_in), .ptr_out(wr_ptr)
   );
   always_comb
      count_d = q.flush_in          ? '0 :
                (wr_req & ~rd_req)  ? count_q + CNT_W'(1) :
                (rd_req & ~wr_req)  ? count_q - CNT_W'(1) : count_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   always_ff @(posedge clk)
      if (wr_req & ~q.flush_in) mem[wr_ptr] <= q.data_in;
   assign q.data_out         = empty ? '0 : mem[rd_ptr];
   assign q.empty_out        = empty;
   assign q.full_out         = full;
   assign q.count_out        = count_q;
   assign q.free_out         = free;
   assign q.almost_empty_out = count_q <= CNT_W'(AE_MARGIN);
   assign q.almost_full_out  = free <= CNT_W'(AF_MARGIN);
`ifdef FIFO_ERR_FLAGS_EN
   fifo_err_t err_q, err_d;
   always_comb begin
      err_d.overflow  = q.err_clr_in ? 1'b0 : err_q.overflow  | (q.write_en_in & full & ~rd_req);
      err_d.underflow = q.err_clr_in ? 1'b0 : err_q.underflow | (q.read_en_in & empty);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) err_q <= '0;
      else     err_q <= err_d;
   assign q.overflow_out  = err_q.overflow;
   assign q.underflow_out = err_q.underflow;
`endif
endmodule
